mge_xcvr_rate_seq: RTL
======================

MGE_XCVR_RATE_SEQ -- requirements
Module: mge_xcvr_rate_seq

Interface
REQ-001 Parameter RESET_HOLD, default 16: cycles xcvr_reset is held high per sequence (≥2).
REQ-002 Parameter TIMEOUT_CYCLES, default 65536: max wait cycles in WAIT_RCFG or WAIT_READY.
REQ-003 Parameter RETRY_MAX, default 2: retries after first attempt before FAIL.
REQ-004 Parameter DEFAULT_RATE, default 2'd0: rate code after reset.
REQ-005 Clock and reset: one clock; reset is synchronous and active-low.
REQ-006 clock  in  1  sole clock; all state changes on rising edge.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 rate_req  in  1  one-cycle request to switch to rate_sel.
REQ-009 rate_sel  in  2  target rate code, sampled with rate_req.
REQ-010 busy  out  1  high whenever state is not IDLE or FAIL.
REQ-011 done  out  1  one-cycle pulse on successful sequence completion.
REQ-012 error  out  1  sticky failure flag.
REQ-013 cur_rate  out  2  rate currently applied to the transceiver.
REQ-014 xcvr_reset  out  1  drives the reset input of the channel reset controller.
REQ-015 reconfig_req  out  1  level request to reconfiguration engine.
REQ-016 reconfig_rate  out  2  rate code for reconfig; valid while reconfig_req high.
REQ-017 reconfig_busy  in  1  reconfiguration engine busy/acknowledge.
REQ-018 tx_ready, rx_ready  in  1 each  ready outputs of the channel reset controller.

Function
REQ-019 States SHALL be HOLD, RCFG_REQ, WAIT_RCFG, WAIT_READY, IDLE, FAIL.
REQ-020 HOLD: xcvr_reset=1, counter runs RESET_HOLD cycles, then RCFG_REQ if target≠cur_rate else WAIT_READY; xcvr_reset=0 from that transition.
REQ-021 RCFG_REQ: xcvr_reset=1, reconfig_req=1 and reconfig_rate=target held until reconfig_busy=1 sampled, then WAIT_RCFG with reconfig_req=0 next cycle.
REQ-022 WAIT_RCFG: xcvr_reset=1 until reconfig_busy=0 sampled; then cur_rate<=target, xcvr_reset=0, go WAIT_READY.
REQ-023 WAIT_READY: require tx_ready=1 and rx_ready=1 on 2 consecutive cycles; then done=1 for one cycle, retry count cleared, go IDLE.
REQ-024 Timeout counter SHALL clear on entering RCFG_REQ or WAIT_READY and count in RCFG_REQ, WAIT_RCFG, WAIT_READY; reaching TIMEOUT_CYCLES counts as attempt failure.
REQ-025 Attempt failure with retries<RETRY_MAX: retries+1, reconfig_req=0, go HOLD with same target; otherwise go FAIL.
REQ-026 FAIL: error=1, xcvr_reset=1, busy=0; cur_rate retains last applied value.
REQ-027 rate_req in IDLE or FAIL: target<=rate_sel, error<=0, retries<=0, go HOLD next cycle; busy high from that cycle.
REQ-028 rate_req while busy SHALL be ignored, without queuing or affecting target.
REQ-029 IDLE with tx_ready=0 or rx_ready=0 for one cycle (link lost): target<=cur_rate, retries<=0, go HOLD; no done until recovery completes.
REQ-030 rate_req and link-lost in the same IDLE cycle: rate_req wins (target=rate_sel).
REQ-031 rate_sel equal to cur_rate SHALL still perform HOLD and WAIT_READY, skipping reconfiguration.
REQ-032 done and error SHALL never be high in the same cycle.

Reset
REQ-033 reset_n=0 sampled: state=HOLD, counters=0, retries=0, target=cur_rate=DEFAULT_RATE, xcvr_reset=1, reconfig_req=0, done=0, error=0, busy=1.
REQ-034 Reset mid-sequence SHALL abort immediately, dropping reconfig_req the next cycle; bring-up (HOLD→WAIT_READY) follows release without reconfiguration.

Verification (RESET_HOLD=4, TIMEOUT_CYCLES=64, RETRY_MAX=1)
REQ-035 Bring-up: release reset, readies high from cycle 10 -> xcvr_reset high 4 cycles, done pulse cycle 12, cur_rate=0, busy=0.
REQ-036 Rate switch: rate_req rate_sel=2, engine acks 3 cycles, busy 5 -> reconfig_rate=2, cur_rate=2 after busy falls, single done pulse.
REQ-037 Timeout/retry: engine never acks -> two attempts of 64 cycles each, then FAIL, error=1, xcvr_reset=1; new rate_req clears error.
REQ-038 Link loss: drop rx_ready one cycle in IDLE -> HOLD with target=cur_rate, no reconfig_req, done on recovery.
REQ-039 Busy drop: rate_req during WAIT_READY -> ignored, target unchanged, one done only.
REQ-040 Mid-op reset: reset_n=0 during WAIT_RCFG -> next cycle reconfig_req=0, cur_rate=DEFAULT_RATE, xcvr_reset=1.

Source files
------------

// File: rtl/mge_xcvr_rate_seq.sv
// Transceiver rate-change sequencer: holds the channel in reset, drives the
// reconfiguration handshake, waits for tx/rx ready and retries on timeout.
module mge_xcvr_rate_seq #(
  parameter int         RESET_HOLD     = 16,
  parameter int         TIMEOUT_CYCLES = 65536,
  parameter int         RETRY_MAX      = 2,
  parameter logic [1:0] DEFAULT_RATE   = 2'd0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rate_req,
  input  logic [1:0] rate_sel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] cur_rate,
  output logic       xcvr_reset,
  output logic       reconfig_req,
  output logic [1:0] reconfig_rate,
  input  logic       reconfig_busy,
  input  logic       tx_ready,
  input  logic       rx_ready
);

  localparam int CMAX = (RESET_HOLD > TIMEOUT_CYCLES) ? RESET_HOLD : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = $clog2(RETRY_MAX + 2);

  typedef enum logic [2:0] {
    HOLD, RCFG_REQ, WAIT_RCFG, WAIT_READY, IDLE, FAIL
  } state_t;

  state_t        st, nxt;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retries;
  logic [1:0]    target;
  logic          rdy_seen;
  logic          rdy, hold_end, tmo_hit, retry_ok, att_fail;

  assign rdy      = tx_ready & rx_ready;
  assign hold_end = (cnt == CW'(RESET_HOLD - 1));
  assign tmo_hit  = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign retry_ok = (retries < RW'(RETRY_MAX));

  always_ff @(posedge clock) begin
    if (!reset_n) st <= HOLD;
    else          st <= nxt;
  end

  // A completing handshake or ready condition takes priority over a timeout
  // landing on the same cycle.
  always_comb begin
    nxt      = st;
    att_fail = 1'b0;
    case (st)
      HOLD:       if (hold_end) nxt = (target != cur_rate) ? RCFG_REQ : WAIT_READY;
      RCFG_REQ:   if (reconfig_busy) nxt = WAIT_RCFG;
                  else if (tmo_hit) att_fail = 1'b1;
      WAIT_RCFG:  if (!reconfig_busy) nxt = WAIT_READY;
                  else if (tmo_hit) att_fail = 1'b1;
      WAIT_READY: if (rdy && rdy_seen) nxt = IDLE;
                  else if (tmo_hit) att_fail = 1'b1;
      IDLE:       if (rate_req || !rdy) nxt = HOLD;
      FAIL:       if (rate_req) nxt = HOLD;
      default:    nxt = HOLD;
    endcase
    if (att_fail) nxt = retry_ok ? HOLD : FAIL;
  end

  always_comb begin
    busy         = 1'b1;
    xcvr_reset   = 1'b1;
    reconfig_req = 1'b0;
    error        = 1'b0;
    case (st)
      RCFG_REQ:   reconfig_req = 1'b1;
      WAIT_READY: xcvr_reset   = 1'b0;
      IDLE:       begin busy = 1'b0; xcvr_reset = 1'b0; end
      FAIL:       begin busy = 1'b0; error = 1'b1; end
      default:    ;
    endcase
  end

  assign reconfig_rate = target;

  // The timeout window spans RCFG_REQ and WAIT_RCFG, so the counter is kept
  // across that one transition and cleared on every other state change.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt      <= '0;
      retries  <= '0;
      target   <= DEFAULT_RATE;
      cur_rate <= DEFAULT_RATE;
      rdy_seen <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (nxt != st && !(st == RCFG_REQ && nxt == WAIT_RCFG)) cnt <= '0;
      else if (st == IDLE || st == FAIL)                     cnt <= '0;
      else                                                   cnt <= cnt + 1'b1;

      rdy_seen <= (st == WAIT_READY) && rdy;
      done     <= (st == WAIT_READY) && (nxt == IDLE);

      if (st == WAIT_RCFG && !reconfig_busy) cur_rate <= target;

      if ((st == IDLE || st == FAIL) && rate_req) begin
        target  <= rate_sel;
        retries <= '0;
      end else if (st == IDLE && !rdy) begin
        target  <= cur_rate;
        retries <= '0;
      end else if (att_fail && retry_ok) begin
        retries <= retries + 1'b1;
      end else if (st == WAIT_READY && nxt == IDLE) begin
        retries <= '0;
      end
    end
  end

endmodule
